// File: rtl/gc_joybus_pkg.sv
// Shared Joybus definitions for the GameCube controller path: bit-cell timing,
// the console poll command and the response transmitter state encoding.
package gc_joybus_pkg;

  // Timing in 25 MHz clock cycles.
  localparam int CLKS_PER_BIT = 100;
  localparam int SHORT_LOW    = 25;
  localparam int LONG_LOW     = 75;
  localparam int STOP_LOW     = 50;
  localparam int TURNAROUND   = 50;
  localparam int RESP_BITS    = 64;

  localparam logic [15:0] POLL_CMD = 16'h4003;

  localparam int CNT_W = 8;
  localparam int BIT_W = 7;

  typedef logic [CNT_W-1:0] cyc_cnt_t;

  localparam cyc_cnt_t CELL_LAST = cyc_cnt_t'(CLKS_PER_BIT - 1);
  localparam cyc_cnt_t TURN_LAST = cyc_cnt_t'(TURNAROUND - 1);
  localparam cyc_cnt_t STOP_LAST = cyc_cnt_t'(STOP_LOW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_LOW,
    ST_HIGH,
    ST_STOP_BIT,
    ST_DONE
  } tx_state_e;

  // A '1' is a short low pulse, a '0' a long one.
  function automatic cyc_cnt_t low_len(input logic bit_val);
    return bit_val ? cyc_cnt_t'(SHORT_LOW) : cyc_cnt_t'(LONG_LOW);
  endfunction

endpackage

// File: rtl/jb_bit_encoder.sv
// Joybus bit-cell generator: a start pulse begins one CLKS_PER_BIT cell whose
// low phase length encodes the bit; starting again on cell_done gives gapless cells.
module jb_bit_encoder
  import gc_joybus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_bit,
  output logic o_drive_low,
  output logic o_cell_done
);

  logic     r_active;
  logic     r_bit;
  cyc_cnt_t r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_bit    <= i_bit;
      r_cnt    <= '0;
    end else if (o_cell_done) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cell_done = r_active && (r_cnt == CELL_LAST);
  assign o_drive_low = r_active && (r_cnt < low_len(r_bit));

endmodule

// File: rtl/console_tx.sv
// Joybus response transmitter: answers a console poll with a 64-bit status frame
// plus stop bit, then clears the receive stage's sticky flags.
module console_tx
  import gc_joybus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 console_did_poll,
  input  logic                 console_cmd_done,
  input  logic [RESP_BITS-1:0] resp_data,
  output logic                 JB_TX_OE,
  output logic                 reset_poll_status,
  output logic                 reset_cmd_done_status,
  output logic                 tx_busy
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(RESP_BITS - 1);

  if (CLKS_PER_BIT > 255 || SHORT_LOW > 255 || LONG_LOW > 255 || STOP_LOW > 255 ||
      TURNAROUND > 255 || STOP_LOW < 1 || TURNAROUND < 1 || RESP_BITS > 127 ||
      !(SHORT_LOW < LONG_LOW && LONG_LOW < CLKS_PER_BIT)) begin : g_timing_check
    $error("console_tx: Joybus timing constants out of range");
  end

  tx_state_e            r_state;
  tx_state_e            w_next;
  logic [RESP_BITS-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit_cnt;
  cyc_cnt_t             r_cyc;
  logic                 r_clr_cmd;

  logic w_poll_req;
  logic w_turn_end;
  logic w_last_bit;
  logic w_enc_start;
  logic w_enc_bit;
  logic w_drive_low;
  logic w_cell_done;

  assign w_poll_req  = console_cmd_done && console_did_poll;
  assign w_turn_end  = (r_state == ST_TURN) && (r_cyc == TURN_LAST);
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_enc_start = w_turn_end || ((r_state == ST_HIGH) && w_cell_done && !w_last_bit);
  // At a cell boundary the shift happens on the same edge, so the next bit is [62].
  assign w_enc_bit   = (r_state == ST_TURN) ? r_shift[RESP_BITS-1] : r_shift[RESP_BITS-2];

  jb_bit_encoder u_bit_encoder (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_enc_start),
    .i_bit       (w_enc_bit),
    .o_drive_low (w_drive_low),
    .o_cell_done (w_cell_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_poll_req) w_next = ST_TURN;
      ST_TURN:     if (w_turn_end) w_next = ST_LOW;
      ST_LOW:      if (!w_drive_low) w_next = ST_HIGH;
      ST_HIGH:     if (w_cell_done) w_next = w_last_bit ? ST_STOP_BIT : ST_LOW;
      ST_STOP_BIT: if (r_cyc == STOP_LAST) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Flags are only looked at in IDLE; anything heard during a frame is our own echo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cyc     <= '0;
      r_clr_cmd <= 1'b0;
    end else begin
      r_clr_cmd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_poll_req) begin
            r_shift <= resp_data;
            r_cyc   <= '0;
          end else if (console_cmd_done && !r_clr_cmd) begin
            r_clr_cmd <= 1'b1;
          end
        end
        ST_TURN: begin
          r_cyc <= r_cyc + 1'b1;
          if (w_turn_end) r_bit_cnt <= '0;
        end
        ST_HIGH: begin
          if (w_cell_done) begin
            r_shift   <= {r_shift[RESP_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_cyc     <= '0;
          end
        end
        ST_STOP_BIT: r_cyc <= r_cyc + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    JB_TX_OE = 1'b0;
    case (r_state)
      ST_LOW, ST_HIGH: JB_TX_OE = w_drive_low;
      ST_STOP_BIT:     JB_TX_OE = 1'b1;
      default:         JB_TX_OE = 1'b0;
    endcase
    reset_poll_status     = (r_state == ST_DONE);
    reset_cmd_done_status = (r_state == ST_DONE) || r_clr_cmd;
    tx_busy               = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_console_tx.sv
// Randomized bench for console_tx: the line waveform is decoded into low pulses
// and compared with the Joybus framing rules computed from the latched status word.
module tb_console_tx;

  localparam int T_TURN  = 50;
  localparam int T_CELL  = 100;
  localparam int T_SHORT = 25;
  localparam int T_LONG  = 75;
  localparam int T_STOP  = 50;
  localparam int NBITS   = 64;
  localparam int FRAME   = T_TURN + NBITS * T_CELL + T_STOP;
  localparam int NCAP    = FRAME + 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        did_poll = 1'b0;
  logic        cmd_done = 1'b0;
  logic [63:0] resp_data = '0;
  logic        jb_tx_oe;
  logic        rst_poll;
  logic        rst_cmd;
  logic        tx_busy;

  int n_total = 0;
  int n_bad   = 0;

  logic trace [0:NCAP];

  console_tx dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .console_did_poll      (did_poll),
    .console_cmd_done      (cmd_done),
    .resp_data             (resp_data),
    .JB_TX_OE              (jb_tx_oe),
    .reset_poll_status     (rst_poll),
    .reset_cmd_done_status (rst_cmd),
    .tx_busy               (tx_busy)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Receive-stage model: sticky flags cleared by the DUT's clear pulses.
  task automatic rx_clear();
    if (rst_poll) did_poll = 1'b0;
    if (rst_cmd)  cmd_done = 1'b0;
  endtask

  task automatic observe(input int n, output int oe_c, output int busy_c,
                         output int poll_c, output int cmd_c);
    oe_c = 0; busy_c = 0; poll_c = 0; cmd_c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      oe_c   += int'(jb_tx_oe);
      busy_c += int'(tx_busy);
      poll_c += int'(rst_poll);
      cmd_c  += int'(rst_cmd);
      rx_clear();
      resp_data = {$urandom, $urandom};
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    int oe_c, busy_c, poll_c, cmd_c;
    observe(n, oe_c, busy_c, poll_c, cmd_c);
    check({name, ":oe_cycles"},   oe_c,   0);
    check({name, ":busy_cycles"}, busy_c, 0);
    check({name, ":poll_pulses"}, poll_c, 0);
    check({name, ":cmd_pulses"},  cmd_c,  0);
  endtask

  // Launch a poll with `data`, capture NCAP cycles, then check pulse timing.
  task automatic run_frame(input string name, input logic [63:0] data, input int chg_at,
                           input logic [63:0] chg_val, input int echo_at);
    int busy_c = 0, busy_last = -1;
    int poll_c = 0, poll_first = -1;
    int cmd_c = 0, cmd_first = -1;
    int ps[$];
    int pl[$];
    int st = 0;
    @(negedge clk);
    resp_data = data;
    cmd_done  = 1'b1;
    did_poll  = 1'b1;
    trace[0]  = 1'b0;
    for (int k = 1; k <= NCAP; k++) begin
      @(negedge clk);
      trace[k] = jb_tx_oe;
      if (tx_busy) begin busy_c++; busy_last = k; end
      if (rst_poll) begin poll_c++; if (poll_first < 0) poll_first = k; end
      if (rst_cmd)  begin cmd_c++;  if (cmd_first < 0)  cmd_first = k;  end
      rx_clear();
      if (k == chg_at) resp_data = chg_val;
      if (k == echo_at) begin cmd_done = 1'b1; did_poll = 1'b1; end
    end
    for (int k = 1; k <= NCAP; k++) begin
      if (trace[k] && !trace[k-1]) st = k;
      if (!trace[k] && trace[k-1]) begin ps.push_back(st); pl.push_back(k - st); end
    end
    check({name, ":low_pulses"}, ps.size(), NBITS + 1);
    for (int i = 0; i < NBITS + 1 && i < ps.size(); i++) begin
      int exp_s, exp_l;
      if (i < NBITS) begin
        exp_s = T_TURN + 1 + i * T_CELL;
        exp_l = data[NBITS-1-i] ? T_SHORT : T_LONG;
      end else begin
        exp_s = T_TURN + NBITS * T_CELL + 1;
        exp_l = T_STOP;
      end
      check($sformatf("%s:p%0d_start", name, i), ps[i], exp_s);
      check($sformatf("%s:p%0d_len", name, i),   pl[i], exp_l);
    end
    check({name, ":poll_pulses"}, poll_c,     1);
    check({name, ":poll_cycle"},  poll_first, FRAME + 1);
    check({name, ":cmd_pulses"},  cmd_c,      1);
    check({name, ":cmd_cycle"},   cmd_first,  FRAME + 1);
    check({name, ":busy_cycles"}, busy_c,     FRAME + 1);
    check({name, ":busy_last"},   busy_last,  FRAME + 1);
  endtask

  initial begin
    int oe_c, busy_c, poll_c, cmd_c;

    // Reset values, then a long idle with no flags.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst:oe",   jb_tx_oe, 0);
    check("rst:poll", rst_poll, 0);
    check("rst:cmd",  rst_cmd,  0);
    check("rst:busy", tx_busy,  0);
    rst_n = 1'b1;
    check_quiet("idle", 1000);

    run_frame("poll_edge_bits", 64'h8000_0000_0000_0001, -1, '0, -1);

    // Non-poll command: one clear pulse, no transmission.
    @(negedge clk);
    cmd_done = 1'b1;
    did_poll = 1'b0;
    observe(50, oe_c, busy_c, poll_c, cmd_c);
    check("nonpoll:cmd_pulses",  cmd_c,  1);
    check("nonpoll:poll_pulses", poll_c, 0);
    check("nonpoll:oe_cycles",   oe_c,   0);
    check("nonpoll:busy_cycles", busy_c, 0);

    run_frame("data_change", '0, T_TURN + 10 * T_CELL + 10, '1, -1);

    // Flags re-asserted mid-frame (our own echo) must not start another frame.
    run_frame("echo", {$urandom, $urandom}, -1, '0, T_TURN + 20 * T_CELL + 3);
    check_quiet("post_echo", 200);

    for (int r = 0; r < 3; r++) begin
      run_frame($sformatf("rand%0d", r), {$urandom, $urandom},
                $urandom_range(1, FRAME), {$urandom, $urandom}, -1);
    end

    // Async reset in the low phase of bit 30.
    @(negedge clk);
    resp_data = {$urandom, $urandom};
    cmd_done  = 1'b1;
    did_poll  = 1'b1;
    repeat (T_TURN + 30 * T_CELL + 10) @(negedge clk);
    check("midrst:pre_oe", jb_tx_oe, 1);
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst:oe",   jb_tx_oe, 0);
    check("midrst:busy", tx_busy,  0);
    check("midrst:poll", rst_poll, 0);
    check("midrst:cmd",  rst_cmd,  0);
    cmd_done = 1'b0;
    did_poll = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_quiet("after_rst", 300);

    run_frame("recover", {$urandom, $urandom}, -1, '0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
